// File: rtl/pipeline_hazard_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | pipeline_hazard_unit_pkg : shared types and constants for the hazard unit  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipeline_hazard_unit_pkg;

    localparam int C_DEF_XLEN     = 32;
    localparam int C_DEF_RA_W     = 5;
    localparam int C_DEF_NSTG     = 3;
    localparam int C_DEF_LOAD_STG = 1;
    localparam int C_DEF_CNT_W    = 32;

    localparam int C_STG_EX  = 0;
    localparam int C_STG_MEM = 1;
    localparam int C_STG_WB  = 2;

    // Scoreboard rd is stored at a fixed maximum width; narrower RA_W is zero-extended.
    localparam int C_SB_RA_W = 8;

    typedef logic [C_SB_RA_W-1:0] sb_rd_t;

    typedef struct packed {
        logic   v;
        sb_rd_t rd;
        logic   we;
        logic   ld;
    } sb_entry_t;

    localparam sb_entry_t C_SB_BUBBLE = '0;

    function automatic logic sb_produces(input sb_entry_t e, input sb_rd_t r);
        return e.v & e.we & (e.rd != '0) & (e.rd == r);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_unit_fwd_select.sv
// +----------------------------------------------------------------------------+
// | pipeline_hazard_unit_fwd_select : lowest-index producer match for one src  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_unit_fwd_select
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int NSTG  = C_DEF_NSTG,
    parameter int RA_W  = C_DEF_RA_W,
    parameter int IDX_W = (NSTG > 1) ? $clog2(NSTG) : 1
) (
    input  sb_entry_t [NSTG-1:0] i_sb,
    input  logic [RA_W-1:0]      i_ra,
    output logic                 o_hit,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_ld
);

    // Walk from oldest to youngest so the youngest producer is the last one written.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        o_ld  = 1'b0;
        for (int k = NSTG - 1; k >= 0; k--) begin
            if (sb_produces(i_sb[k], sb_rd_t'(i_ra))) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(k);
                o_ld  = i_sb[k].ld;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
// +----------------------------------------------------------------------------+
// | pipeline_hazard_unit : operand forwarding, load-use stall and flush control|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int XLEN     = C_DEF_XLEN,
    parameter int RA_W     = C_DEF_RA_W,
    parameter int NSTG     = C_DEF_NSTG,
    parameter int LOAD_STG = C_DEF_LOAD_STG,
    parameter int CNT_W    = C_DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid_i,
    input  logic [RA_W-1:0]      id_rs1_i,
    input  logic [RA_W-1:0]      id_rs2_i,
    input  logic                 id_rs1_re_i,
    input  logic                 id_rs2_re_i,
    input  logic [RA_W-1:0]      id_rd_i,
    input  logic                 id_we_i,
    input  logic                 id_is_load_i,
    input  logic [XLEN-1:0]      rf_rd1_i,
    input  logic [XLEN-1:0]      rf_rd2_i,
    input  logic [NSTG*XLEN-1:0] stg_data_i,
    input  logic                 ex_busy_i,
    input  logic                 ex_redirect_i,
    output logic [XLEN-1:0]      opA_o,
    output logic [XLEN-1:0]      opB_o,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    localparam int C_IDX_W = (NSTG > 1) ? $clog2(NSTG) : 1;

    sb_entry_t [NSTG-1:0] r_sb;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic [CNT_W-1:0]     r_flush_cnt;

    logic [XLEN-1:0]      w_stg [NSTG];
    logic                 w_hit_a, w_hit_b;
    logic                 w_ld_a, w_ld_b;
    logic [C_IDX_W-1:0]   w_idx_a, w_idx_b;
    logic                 w_hz_a, w_hz_b;
    logic                 w_load_use;
    logic                 w_stall;
    logic                 w_flush;
    logic                 w_accept;
    sb_entry_t            w_id_entry;
    sb_entry_t            w_s0_next;

    generate
        for (genvar k = 0; k < NSTG; k++) begin : g_stg
            assign w_stg[k] = stg_data_i[k*XLEN +: XLEN];
        end
    endgenerate

    pipeline_hazard_unit_fwd_select #(
        .NSTG  (NSTG),
        .RA_W  (RA_W),
        .IDX_W (C_IDX_W)
    ) u_fwd_rs1 (
        .i_sb  (r_sb),
        .i_ra  (id_rs1_i),
        .o_hit (w_hit_a),
        .o_idx (w_idx_a),
        .o_ld  (w_ld_a)
    );

    pipeline_hazard_unit_fwd_select #(
        .NSTG  (NSTG),
        .RA_W  (RA_W),
        .IDX_W (C_IDX_W)
    ) u_fwd_rs2 (
        .i_sb  (r_sb),
        .i_ra  (id_rs2_i),
        .o_hit (w_hit_b),
        .o_idx (w_idx_b),
        .o_ld  (w_ld_b)
    );

    // A load only hazards while its data has not yet reached a forwardable stage.
    assign w_hz_a     = id_rs1_re_i & w_hit_a & w_ld_a & (int'(w_idx_a) < LOAD_STG);
    assign w_hz_b     = id_rs2_re_i & w_hit_b & w_ld_b & (int'(w_idx_b) < LOAD_STG);
    assign w_load_use = id_valid_i & (w_hz_a | w_hz_b);

    assign w_stall = ex_busy_i | (w_load_use & ~ex_redirect_i);
    assign w_flush = ex_redirect_i & ~ex_busy_i;

    assign opA_o = (id_rs1_re_i & w_hit_a) ? w_stg[w_idx_a] : rf_rd1_i;
    assign opB_o = (id_rs2_re_i & w_hit_b) ? w_stg[w_idx_b] : rf_rd2_i;

    assign stall_o     = w_stall;
    assign flush_o     = w_flush;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

    assign w_accept   = id_valid_i & ~w_stall & ~w_flush;
    assign w_id_entry = '{v: 1'b1, rd: sb_rd_t'(id_rd_i), we: id_we_i, ld: id_is_load_i};
    assign w_s0_next  = w_accept ? w_id_entry : C_SB_BUBBLE;

    // While EX is busy its entry stays put and a bubble opens up behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb <= '0;
        end else if (!ex_busy_i) begin
            r_sb[0] <= w_s0_next;
            for (int k = 1; k < NSTG; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
        end else begin
            for (int k = 1; k < NSTG; k++) begin
                r_sb[k] <= (k == 1) ? C_SB_BUBBLE : r_sb[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
// +----------------------------------------------------------------------------+
// | tb_pipeline_hazard_unit : directed bench with a behavioural reference model|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_hazard_unit;

    localparam int XLEN     = 32;
    localparam int RA_W     = 5;
    localparam int NSTG     = 3;
    localparam int LOAD_STG = 1;
    localparam longint C_MAX32 = 64'h0000_0000_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic [RA_W-1:0] rs1 = '0, rs2 = '0, rd = '0;
    logic            re1 = 1'b0, re2 = 1'b0, we = 1'b0, ld = 1'b0;
    logic [XLEN-1:0] rf1 = 32'hAAAA_0001;
    logic [XLEN-1:0] rf2 = 32'hBBBB_0002;
    logic [XLEN-1:0] sd [NSTG];
    logic            busy = 1'b0, redir = 1'b0;
    logic [NSTG*XLEN-1:0] stg_data;

    logic [XLEN-1:0] opA, opB, s_opA, s_opB;
    logic            stall, flush, s_stall, s_flush;
    logic [31:0]     scnt, fcnt;
    logic [1:0]      s_scnt, s_fcnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: what each stage holds, as plain per-stage fields.
    bit     m_v [NSTG];
    bit     m_we[NSTG];
    bit     m_ld[NSTG];
    int     m_rd[NSTG];
    longint m_scnt = 0;
    longint m_fcnt = 0;

    assign stg_data = {sd[2], sd[1], sd[0]};

    always #5 clk = ~clk;

    pipeline_hazard_unit #(
        .XLEN(XLEN), .RA_W(RA_W), .NSTG(NSTG), .LOAD_STG(LOAD_STG), .CNT_W(32)
    ) u_dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_re_i(re1), .id_rs2_re_i(re2),
        .id_rd_i(rd), .id_we_i(we), .id_is_load_i(ld),
        .rf_rd1_i(rf1), .rf_rd2_i(rf2), .stg_data_i(stg_data),
        .ex_busy_i(busy), .ex_redirect_i(redir),
        .opA_o(opA), .opB_o(opB), .stall_o(stall), .flush_o(flush),
        .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
    );

    pipeline_hazard_unit #(
        .XLEN(XLEN), .RA_W(RA_W), .NSTG(NSTG), .LOAD_STG(LOAD_STG), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst(rst), .id_valid_i(id_valid),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_re_i(re1), .id_rs2_re_i(re2),
        .id_rd_i(rd), .id_we_i(we), .id_is_load_i(ld),
        .rf_rd1_i(rf1), .rf_rd2_i(rf2), .stg_data_i(stg_data),
        .ex_busy_i(busy), .ex_redirect_i(redir),
        .opA_o(s_opA), .opB_o(s_opB), .stall_o(s_stall), .flush_o(s_flush),
        .stall_cnt_o(s_scnt), .flush_cnt_o(s_fcnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int prod(input int r);
        for (int k = 0; k < NSTG; k++) begin
            if (m_v[k] && m_we[k] && m_rd[k] != 0 && m_rd[k] == r) return k;
        end
        return -1;
    endfunction

    function automatic bit src_hz(input bit re, input int r);
        int p;
        p = prod(r);
        if (!re || p < 0) return 1'b0;
        return m_ld[p] && (p < LOAD_STG);
    endfunction

    function automatic bit exp_lu();
        return id_valid && (src_hz(re1, int'(rs1)) || src_hz(re2, int'(rs2)));
    endfunction

    function automatic bit exp_stall();
        return busy || (exp_lu() && !redir);
    endfunction

    function automatic bit exp_flush();
        return redir && !busy;
    endfunction

    function automatic logic [XLEN-1:0] exp_op(input bit re, input int r, input logic [XLEN-1:0] rf);
        int p;
        p = prod(r);
        return (re && p >= 0) ? sd[p] : rf;
    endfunction

    function automatic longint sat3(input longint v);
        return (v > 3) ? 3 : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                m_v[k] <= 1'b0; m_we[k] <= 1'b0; m_ld[k] <= 1'b0; m_rd[k] <= 0;
            end
            m_scnt <= 0;
            m_fcnt <= 0;
        end else begin
            if (exp_stall() && m_scnt < C_MAX32) m_scnt <= m_scnt + 1;
            if (exp_flush() && m_fcnt < C_MAX32) m_fcnt <= m_fcnt + 1;
            m_v[2] <= m_v[1]; m_we[2] <= m_we[1]; m_ld[2] <= m_ld[1]; m_rd[2] <= m_rd[1];
            if (!busy) begin
                m_v[1] <= m_v[0]; m_we[1] <= m_we[0]; m_ld[1] <= m_ld[0]; m_rd[1] <= m_rd[0];
                if (id_valid && !exp_stall() && !exp_flush()) begin
                    m_v[0] <= 1'b1; m_we[0] <= we; m_ld[0] <= ld; m_rd[0] <= int'(rd);
                end else begin
                    m_v[0] <= 1'b0; m_we[0] <= 1'b0; m_ld[0] <= 1'b0; m_rd[0] <= 0;
                end
            end else begin
                m_v[1] <= 1'b0; m_we[1] <= 1'b0; m_ld[1] <= 1'b0; m_rd[1] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("model_stall", 64'(stall), 64'(exp_stall()));
            chk("model_flush", 64'(flush), 64'(exp_flush()));
            if (!exp_lu()) begin
                chk("model_opA", 64'(opA), 64'(exp_op(re1, int'(rs1), rf1)));
                chk("model_opB", 64'(opB), 64'(exp_op(re2, int'(rs2), rf2)));
            end
            chk("model_stall_cnt", 64'(scnt), 64'(m_scnt));
            chk("model_flush_cnt", 64'(fcnt), 64'(m_fcnt));
            chk("model_sat_stall_cnt", 64'(s_scnt), 64'(sat3(m_scnt)));
            chk("model_sat_flush_cnt", 64'(s_fcnt), 64'(sat3(m_fcnt)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input bit v, input int d, input bit w, input bit l,
                          input int a, input bit ea, input int b, input bit eb);
        id_valid = v; rd = RA_W'(d); we = w; ld = l;
        rs1 = RA_W'(a); re1 = ea; rs2 = RA_W'(b); re2 = eb;
    endtask

    task automatic idle();
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        busy = 1'b0; redir = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        sd[0] = 32'h0; sd[1] = 32'h0; sd[2] = 32'h0;
        do_reset();
        chk_en = 1'b1;

        // Post-reset idle: no stall/flush, operands come from the register file.
        id_set(0, 0, 0, 0, 3, 1, 4, 1);
        @(negedge clk);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_opA", 64'(opA), 64'hAAAA_0001);
        chk("rst_opB", 64'(opB), 64'hBBBB_0002);
        chk("rst_stall_cnt", 64'(scnt), 64'd0);
        tick();

        // addi x5 in EX, ID reads x5.
        id_set(1, 5, 1, 0, 0, 0, 0, 0);
        tick();
        id_set(1, 0, 0, 0, 5, 1, 0, 0);
        sd[0] = 32'h0000_0007; sd[1] = 32'h33; sd[2] = 32'h22;
        @(negedge clk);
        chk("ex_fwd_opA", 64'(opA), 64'h7);
        chk("ex_fwd_stall", 64'(stall), 64'd0);
        tick();

        // x5 in EX and WB: youngest wins; then MEM-only, then WB-only.
        id_set(1, 5, 1, 0, 0, 0, 0, 0);
        tick();
        id_set(1, 0, 0, 0, 5, 1, 0, 0);
        sd[0] = 32'h11;
        @(negedge clk);
        chk("youngest_opA", 64'(opA), 64'h11);
        tick();
        id_set(1, 0, 0, 0, 0, 0, 5, 1);
        @(negedge clk);
        chk("mem_fwd_opB", 64'(opB), 64'h33);
        tick();
        @(negedge clk);
        chk("wb_fwd_opB", 64'(opB), 64'h22);
        tick();
        idle();
        tick();

        // lw x6 in EX, ID reads x6 as rs2.
        id_set(1, 6, 1, 1, 0, 0, 0, 0);
        tick();
        id_set(1, 7, 1, 0, 0, 0, 6, 1);
        sd[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lu_stall", 64'(stall), 64'd1);
        tick();
        @(negedge clk);
        chk("lu_release_stall", 64'(stall), 64'd0);
        chk("lu_opB", 64'(opB), 64'hDEAD_BEEF);
        chk("lu_stall_cnt", 64'(scnt), 64'd1);
        tick();
        idle();
        tick();

        // Redirect coincides with load-use.
        id_set(1, 8, 1, 1, 0, 0, 0, 0);
        tick();
        id_set(1, 9, 1, 0, 8, 1, 0, 0);
        redir = 1'b1;
        @(negedge clk);
        chk("redir_flush", 64'(flush), 64'd1);
        chk("redir_stall", 64'(stall), 64'd0);
        tick();
        redir = 1'b0;
        id_set(1, 0, 0, 0, 9, 1, 8, 1);
        sd[0] = 32'h99; sd[1] = 32'h88;
        @(negedge clk);
        chk("redir_bubble_opA", 64'(opA), 64'hAAAA_0001);
        chk("redir_mem_opB", 64'(opB), 64'h88);
        chk("redir_flush_cnt", 64'(fcnt), 64'd1);
        tick();
        idle();
        tick();

        // EX busy for 4 cycles, redirect ignored meanwhile.
        do_reset();
        id_set(1, 12, 1, 0, 0, 0, 0, 0);
        tick();
        id_set(1, 10, 1, 0, 0, 0, 0, 0);
        tick();
        busy = 1'b1;
        id_set(1, 11, 1, 0, 10, 1, 12, 1);
        sd[0] = 32'hA0; sd[1] = 32'hB0; sd[2] = 32'hC0;
        @(negedge clk);
        chk("busy1_stall", 64'(stall), 64'd1);
        chk("busy1_opB", 64'(opB), 64'hB0);
        tick();
        redir = 1'b1;
        @(negedge clk);
        chk("busy2_flush", 64'(flush), 64'd0);
        chk("busy2_opB_wb", 64'(opB), 64'hC0);
        tick();
        redir = 1'b0;
        @(negedge clk);
        chk("busy3_opB_rf", 64'(opB), 64'hBBBB_0002);
        tick();
        tick();
        busy = 1'b0;
        id_set(0, 0, 0, 0, 10, 1, 0, 0);
        @(negedge clk);
        chk("busy_end_stall", 64'(stall), 64'd0);
        chk("busy_ex_kept_opA", 64'(opA), 64'hA0);
        chk("busy_stall_cnt", 64'(scnt), 64'd4);
        chk("busy_sat_stall_cnt", 64'(s_scnt), 64'd3);
        chk("busy_flush_cnt", 64'(fcnt), 64'd0);
        tick();

        // x0 never forwards or hazards.
        id_set(1, 0, 1, 0, 0, 0, 0, 0);
        tick();
        id_set(1, 0, 1, 1, 0, 1, 0, 0);
        sd[0] = 32'h5;
        @(negedge clk);
        chk("x0_opA", 64'(opA), 64'hAAAA_0001);
        tick();
        id_set(1, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("x0_load_stall", 64'(stall), 64'd0);
        chk("x0_opB", 64'(opB), 64'hBBBB_0002);
        tick();

        // Reset while busy discards everything, including the ID instruction.
        id_set(1, 14, 1, 0, 0, 0, 0, 0);
        tick();
        busy = 1'b1;
        id_set(1, 13, 1, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy = 1'b0;
        id_set(0, 0, 0, 0, 14, 1, 13, 1);
        sd[0] = 32'hE0; sd[1] = 32'hE1; sd[2] = 32'hE2;
        @(negedge clk);
        chk("rstbusy_opA", 64'(opA), 64'hAAAA_0001);
        chk("rstbusy_opB", 64'(opB), 64'hBBBB_0002);
        chk("rstbusy_stall", 64'(stall), 64'd0);
        chk("rstbusy_stall_cnt", 64'(scnt), 64'd0);
        chk("rstbusy_flush_cnt", 64'(fcnt), 64'd0);
        tick();
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
